vga_timing_gen: RTL and testbench

- Generates 640x480 @ 60 Hz VGA raster timing from the 100 MHz system clock.
- Drives DE, x_pixel and y_pixel into the colour-pattern and pixel-source blocks.
- Drives h_sync and v_sync directly to the VGA connector.
- Derives an internal 25 MHz pixel-enable tick by clock division; the block uses no second clock.

---
 rtl/vga_timing_gen_if.sv | 35 +++
 rtl/vga_timing_gen.sv | 99 +++++++++
 tb/tb_vga_timing_gen.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle shared between the VGA timing generator and the
// blocks that consume its pixel coordinates and sync pulses.
interface vga_timing_gen_if;

   logic       pclk_tick;
   logic [9:0] x_pixel;
   logic [9:0] y_pixel;
   logic       DE;
   logic       h_sync;
   logic       v_sync;
   logic       frame_start;

   // The timing generator drives every signal of the bundle
   modport master (
      output pclk_tick,
      output x_pixel,
      output y_pixel,
      output DE,
      output h_sync,
      output v_sync,
      output frame_start
   );

   // Pattern generators, pixel sources and the connector only listen
   modport slave (
      input pclk_tick,
      input x_pixel,
      input y_pixel,
      input DE,
      input h_sync,
      input v_sync,
      input frame_start
   );

endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. It divides the system clock down to a
// pixel-rate enable, walks a horizontal/vertical counter pair across the
// full raster (visible area plus blanking), and decodes DE, the sync pulses
// and a frame-start marker combinationally from those counters. Because
// every output comes from the same registered counters, all outputs change
// on the same clock edge.
module vga_timing_gen #(
   parameter int CLK_DIV   = 4,
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int SYNC_POL  = 0
) (
   input logic               clk,
   input logic               reset,
   vga_timing_gen_if.master  vga
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = $clog2(CLK_DIV);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
   localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic       SYNC_ACT   = (SYNC_POL != 0);

   logic [DIV_W-1:0] div_cnt;
   logic [9:0]       h_cnt;
   logic [9:0]       v_cnt;
   logic             tick;
   logic             h_last;
   logic             v_last;
   logic             in_hsync;
   logic             in_vsync;

   assign tick   = (div_cnt == DIV_LAST);
   assign h_last = (h_cnt == H_LAST);
   assign v_last = (v_cnt == V_LAST);

   // Clock divider: free-running modulo-CLK_DIV count; its last value is the
   // pixel-rate enable used by the raster counters and downstream blocks.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // Raster counters: the column advances once per pixel tick, and the row
   // advances only when the column wraps, so the end of the last line takes
   // both counters back to the origin in a single clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (tick) begin
         if (h_last) begin
            h_cnt <= '0;
            if (v_last) begin
               v_cnt <= '0;
            end else begin
               v_cnt <= v_cnt + 1'b1;
            end
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end

   // Output decode: pure functions of the registered counters, so the sync
   // pulses, DE and coordinates never skew relative to one another.
   always_comb begin
      in_hsync        = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
      in_vsync        = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
      vga.pclk_tick   = tick;
      vga.x_pixel     = h_cnt;
      vga.y_pixel     = v_cnt;
      vga.DE          = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
      vga.h_sync      = in_hsync ? SYNC_ACT : ~SYNC_ACT;
      vga.v_sync      = in_vsync ? SYNC_ACT : ~SYNC_ACT;
      vga.frame_start = tick && h_last && v_last;
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for the VGA timing generator. Instance A uses the standard
// 640x480 timing with active-low sync; instance B uses a tiny raster with an
// odd divider and active-high sync so whole frames fit in a short run. Both
// are compared every clock against a model that derives the raster position
// arithmetically from the number of clocks since reset release.
module tb_vga_timing_gen;

   localparam int B_DIV = 3;
   localparam int B_HV  = 10;
   localparam int B_HF  = 2;
   localparam int B_HS  = 3;
   localparam int B_HB  = 1;
   localparam int B_VV  = 5;
   localparam int B_VF  = 1;
   localparam int B_VS  = 2;
   localparam int B_VB  = 2;

   typedef struct packed {
      bit tick;
      int x;
      int y;
      bit de;
      bit hs;
      bit vs;
      bit fs;
   } raster_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   vectors     = 0;
   int   miscompares = 0;
   int   k           = 0;
   int   clkTotal    = 0;
   int   prevFs      = -1;

   vga_timing_gen_if ifA ();
   vga_timing_gen_if ifB ();

   vga_timing_gen dutA (
      .clk   (clk),
      .reset (reset),
      .vga   (ifA)
   );

   vga_timing_gen #(
      .CLK_DIV   (B_DIV),
      .H_VISIBLE (B_HV),
      .H_FRONT   (B_HF),
      .H_SYNC    (B_HS),
      .H_BACK    (B_HB),
      .V_VISIBLE (B_VV),
      .V_FRONT   (B_VF),
      .V_SYNC    (B_VS),
      .V_BACK    (B_VB),
      .SYNC_POL  (1)
   ) dutB (
      .clk   (clk),
      .reset (reset),
      .vga   (ifB)
   );

   // 100 MHz system clock
   always #5 clk = ~clk;

   // Clocks elapsed since reset release; held at zero while reset is high
   always @(posedge clk or posedge reset) begin
      if (reset) k <= 0;
      else       k <= k + 1;
   end

   // Free-running clock count for measuring frame periods
   always @(posedge clk) clkTotal <= clkTotal + 1;

   // Raster position as a pure function of elapsed clocks: completed pixel
   // periods, reduced modulo the frame size, split into column and row.
   function automatic raster_t model(input int kk, input int d,
                                     input int hv, input int hf, input int hs, input int hb,
                                     input int vv, input int vf, input int vs, input int vb,
                                     input bit pol);
      raster_t r;
      int ht, vt, p;
      ht   = hv + hf + hs + hb;
      vt   = vv + vf + vs + vb;
      p    = (kk / d) % (ht * vt);
      r.x  = p % ht;
      r.y  = p / ht;
      r.tick = ((kk % d) == d - 1);
      r.de = (r.x < hv) && (r.y < vv);
      r.hs = ((r.x >= hv + hf) && (r.x < hv + hf + hs)) ? pol : !pol;
      r.vs = ((r.y >= vv + vf) && (r.y < vv + vf + vs)) ? pol : !pol;
      r.fs = r.tick && (p == ht * vt - 1);
      return r;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: actual=%0d expected=%0d (k=%0d, t=%0t)", name, actual, expected, k, $time);
      end
   endtask

   task automatic checkAll(input string tag, input raster_t e,
                           input logic tick, input logic [9:0] x, input logic [9:0] y,
                           input logic de, input logic hs, input logic vs, input logic fs);
      checkOutput({tag, ".pclk_tick"},   int'(tick), int'(e.tick));
      checkOutput({tag, ".x_pixel"},     int'(x),    e.x);
      checkOutput({tag, ".y_pixel"},     int'(y),    e.y);
      checkOutput({tag, ".DE"},          int'(de),   int'(e.de));
      checkOutput({tag, ".h_sync"},      int'(hs),   int'(e.hs));
      checkOutput({tag, ".v_sync"},      int'(vs),   int'(e.vs));
      checkOutput({tag, ".frame_start"}, int'(fs),   int'(e.fs));
   endtask

   // Every-clock scoreboard for both instances, sampled on the falling edge
   always @(negedge clk) begin
      checkAll("A", model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0),
               ifA.pclk_tick, ifA.x_pixel, ifA.y_pixel, ifA.DE,
               ifA.h_sync, ifA.v_sync, ifA.frame_start);
      checkAll("B", model(k, B_DIV, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB, 1'b1),
               ifB.pclk_tick, ifB.x_pixel, ifB.y_pixel, ifB.DE,
               ifB.h_sync, ifB.v_sync, ifB.frame_start);
   end

   // Frame period of instance B: 16 columns x 10 rows x 3 clocks = 480
   always @(negedge clk) begin
      if (reset) begin
         prevFs = -1;
      end else if (ifB.frame_start === 1'b1) begin
         if (prevFs >= 0) checkOutput("B.frame_period", clkTotal - prevFs, 480);
         prevFs = clkTotal;
      end
   end

   // Hold reset for a few clocks and release it on a falling edge
   task automatic applyStimulus(input int holdClocks);
      reset = 1'b1;
      repeat (holdClocks) @(negedge clk);
      reset = 1'b0;
   endtask

   // Advance to the falling edge where k equals n, with a bounded wait
   task automatic waitForCount(input int n);
      for (int i = 0; i < 20000; i++) begin
         if (k == n) return;
         @(negedge clk);
      end
      vectors++;
      miscompares++;
      $display("[TB] FAIL wait_k: actual=%0d expected=%0d", k, n);
   endtask

   // Startup timing right after a reset release
   task automatic checkStartup();
      waitForCount(0);
      checkOutput("A.k0.tick", int'(ifA.pclk_tick), 0);
      checkOutput("A.k0.x",    int'(ifA.x_pixel),   0);
      checkOutput("A.k0.y",    int'(ifA.y_pixel),   0);
      checkOutput("A.k0.DE",   int'(ifA.DE),        1);
      checkOutput("A.k0.hs",   int'(ifA.h_sync),    1);
      checkOutput("A.k0.vs",   int'(ifA.v_sync),    1);
      checkOutput("B.k0.hs",   int'(ifB.h_sync),    0);
      checkOutput("B.k0.vs",   int'(ifB.v_sync),    0);
      waitForCount(2);
      checkOutput("A.k2.tick", int'(ifA.pclk_tick), 0);
      checkOutput("B.k2.tick", int'(ifB.pclk_tick), 1);
      waitForCount(3);
      checkOutput("A.k3.tick", int'(ifA.pclk_tick), 1);
      checkOutput("A.k3.x",    int'(ifA.x_pixel),   0);
      checkOutput("B.k3.x",    int'(ifB.x_pixel),   1);
      waitForCount(4);
      checkOutput("A.k4.tick", int'(ifA.pclk_tick), 0);
      checkOutput("A.k4.x",    int'(ifA.x_pixel),   1);
   endtask

   initial begin
      applyStimulus(3);
      checkStartup();

      // Instance B vertical sync edge and frame wrap
      waitForCount(287);
      checkOutput("B.k287.y",  int'(ifB.y_pixel), 5);
      checkOutput("B.k287.vs", int'(ifB.v_sync),  0);
      waitForCount(288);
      checkOutput("B.k288.y",  int'(ifB.y_pixel), 6);
      checkOutput("B.k288.x",  int'(ifB.x_pixel), 0);
      checkOutput("B.k288.vs", int'(ifB.v_sync),  1);
      waitForCount(479);
      checkOutput("B.k479.x",  int'(ifB.x_pixel),     15);
      checkOutput("B.k479.y",  int'(ifB.y_pixel),     9);
      checkOutput("B.k479.fs", int'(ifB.frame_start), 1);
      waitForCount(480);
      checkOutput("B.k480.x",  int'(ifB.x_pixel),     0);
      checkOutput("B.k480.y",  int'(ifB.y_pixel),     0);
      checkOutput("B.k480.fs", int'(ifB.frame_start), 0);

      // Instance A: end of visible line, sync pulse edges, line wrap
      waitForCount(2559);
      checkOutput("A.x639.DE", int'(ifA.DE), 1);
      waitForCount(2560);
      checkOutput("A.x640.x",  int'(ifA.x_pixel), 640);
      checkOutput("A.x640.DE", int'(ifA.DE),      0);
      waitForCount(2623);
      checkOutput("A.x655.hs", int'(ifA.h_sync), 1);
      waitForCount(2624);
      checkOutput("A.x656.hs", int'(ifA.h_sync), 0);
      waitForCount(3007);
      checkOutput("A.x751.hs", int'(ifA.h_sync), 0);
      waitForCount(3008);
      checkOutput("A.x752.hs", int'(ifA.h_sync), 1);
      waitForCount(3199);
      checkOutput("A.x799.x",  int'(ifA.x_pixel), 799);
      checkOutput("A.x799.y",  int'(ifA.y_pixel), 0);
      waitForCount(3200);
      checkOutput("A.wrap.x",  int'(ifA.x_pixel), 0);
      checkOutput("A.wrap.y",  int'(ifA.y_pixel), 1);

      // Reset asserted between clock edges in the middle of a pixel period
      waitForCount(4401);
      checkOutput("A.pre.x", int'(ifA.x_pixel), 300);
      checkOutput("A.pre.y", int'(ifA.y_pixel), 1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("A.rst.tick", int'(ifA.pclk_tick),   0);
      checkOutput("A.rst.x",    int'(ifA.x_pixel),     0);
      checkOutput("A.rst.y",    int'(ifA.y_pixel),     0);
      checkOutput("A.rst.DE",   int'(ifA.DE),          1);
      checkOutput("A.rst.hs",   int'(ifA.h_sync),      1);
      checkOutput("A.rst.vs",   int'(ifA.v_sync),      1);
      checkOutput("A.rst.fs",   int'(ifA.frame_start), 0);
      checkOutput("B.rst.x",    int'(ifB.x_pixel),     0);
      checkOutput("B.rst.y",    int'(ifB.y_pixel),     0);
      checkOutput("B.rst.hs",   int'(ifB.h_sync),      0);
      checkOutput("B.rst.vs",   int'(ifB.v_sync),      0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      checkStartup();

      // A little more free running after the restart, then wrap up
      waitForCount(1000);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
